// File: rtl/shot_entry_fsm.sv
// ---------------------------------------------------------------------------
// shot_entry_fsm
// Keyboard shot-entry stage ahead of the shot decider. Collects a column
// letter (A-J) and a row digit (1-9, 0 = row 10) from strobed PS/2 set-2 scan
// codes. It waits for Enter, then presents the coordinate for exactly one
// cycle and passes the turn to the other player. Outside the fire cycle the
// decider sees the "no shot" code 4'hF on both coordinate outputs.
//
// Optional feature: define SHOT_TIMEOUT_EN to discard a partial entry after
// TIMEOUT_CYCLES idle cycles.
//
// Ports
//   clock27      in   system clock, rising edge
//   reset        in   asynchronous, active-high
//   key_valid    in   one-cycle strobe qualifying key_code
//   key_code     in   [7:0] PS/2 set-2 scan code byte
//   letter       out  [3:0] column to decider (0-9 in fire cycle, else F)
//   number       out  [3:0] row to decider (1-9, 0 in fire cycle, else F)
//   shot_valid   out  high only in the fire cycle
//   playerTurn   out  0 = player one, 1 = player two
//   cur_letter   out  [3:0] buffered letter for display (F if none)
//   cur_number   out  [3:0] buffered number for display (F if none)
//   entry_state  out  [1:0] 0 IDLE, 1 HAVE_LETTER, 2 HAVE_NUMBER, 3 FIRE
// ---------------------------------------------------------------------------
module shot_entry_fsm #(
    parameter int unsigned TIMEOUT_CYCLES = 27000000
) (
    input  logic       clock27,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    output logic [3:0] letter,
    output logic [3:0] number,
    output logic       shot_valid,
    output logic       playerTurn,
    output logic [3:0] cur_letter,
    output logic [3:0] cur_number,
    output logic [1:0] entry_state
);

    localparam int unsigned NIB_W = 4;
    localparam logic [NIB_W-1:0] NO_SHOT = 4'hF;

    localparam logic [7:0] KC_BREAK = 8'hF0;
    localparam logic [7:0] KC_EXT   = 8'hE0;
    localparam logic [7:0] KC_ENTER = 8'h5A;
    localparam logic [7:0] KC_BKSP  = 8'h66;
    localparam logic [7:0] KC_ESC   = 8'h76;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_HAVE_LETTER = 2'd1,
        ST_HAVE_NUMBER = 2'd2,
        ST_FIRE        = 2'd3
    } state_t;

    // Degenerate timeout values make no sense for the counter compare.
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    // Letter decode: {hit, column 0-9}.
    function automatic logic [NIB_W:0] dec_letter(input logic [7:0] c);
        case (c)
            8'h1C:   return {1'b1, 4'd0};
            8'h32:   return {1'b1, 4'd1};
            8'h21:   return {1'b1, 4'd2};
            8'h23:   return {1'b1, 4'd3};
            8'h24:   return {1'b1, 4'd4};
            8'h2B:   return {1'b1, 4'd5};
            8'h34:   return {1'b1, 4'd6};
            8'h33:   return {1'b1, 4'd7};
            8'h43:   return {1'b1, 4'd8};
            8'h3B:   return {1'b1, 4'd9};
            default: return {1'b0, NO_SHOT};
        endcase
    endfunction

    // Digit decode: {hit, row value}; key 0 encodes row 10 as 0.
    function automatic logic [NIB_W:0] dec_digit(input logic [7:0] c);
        case (c)
            8'h16:   return {1'b1, 4'd1};
            8'h1E:   return {1'b1, 4'd2};
            8'h26:   return {1'b1, 4'd3};
            8'h25:   return {1'b1, 4'd4};
            8'h2E:   return {1'b1, 4'd5};
            8'h36:   return {1'b1, 4'd6};
            8'h3D:   return {1'b1, 4'd7};
            8'h3E:   return {1'b1, 4'd8};
            8'h46:   return {1'b1, 4'd9};
            8'h45:   return {1'b1, 4'd0};
            default: return {1'b0, NO_SHOT};
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [NIB_W-1:0] buf_let_q, buf_let_d;
    logic [NIB_W-1:0] buf_num_q, buf_num_d;
    logic [NIB_W-1:0] letter_q, letter_d;
    logic [NIB_W-1:0] number_q, number_d;
    logic             shot_q, shot_d;
    logic             turn_q, turn_d;
    logic             brk_q, brk_d;
    logic             ext_q, ext_d;

    logic             key_take;
    logic             is_key;
    logic [NIB_W:0]   let_dec;
    logic [NIB_W:0]   dig_dec;

`ifdef SHOT_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    // No idle counter: partial entries persist until Backspace, Escape or reset.
`endif

    assign let_dec = dec_letter(key_code);
    assign dig_dec = dec_digit(key_code);

    // State and output registers.
    always_ff @(posedge clock27 or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            buf_let_q <= NO_SHOT;
            buf_num_q <= NO_SHOT;
            letter_q  <= NO_SHOT;
            number_q  <= NO_SHOT;
            shot_q    <= 1'b0;
            turn_q    <= 1'b0;
            brk_q     <= 1'b0;
            ext_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_let_q <= buf_let_d;
            buf_num_q <= buf_num_d;
            letter_q  <= letter_d;
            number_q  <= number_d;
            shot_q    <= shot_d;
            turn_q    <= turn_d;
            brk_q     <= brk_d;
            ext_q     <= ext_d;
        end
    end

`ifdef SHOT_TIMEOUT_EN
    // Idle counter register.
    always_ff @(posedge clock27 or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Prefix filtering, entry state machine and registered-output inputs.
    always_comb begin
        state_d   = state_q;
        buf_let_d = buf_let_q;
        buf_num_d = buf_num_q;
        turn_d    = turn_q;
        brk_d     = brk_q;
        ext_d     = ext_q;
        is_key    = 1'b0;
`ifdef SHOT_TIMEOUT_EN
        cnt_d     = '0;
`endif

        // Strobes landing in the fire cycle are dropped entirely.
        key_take = key_valid && (state_q != ST_FIRE);

        if (key_take) begin
            if (brk_q) begin
                // Release byte following F0 is swallowed.
                brk_d = 1'b0;
                ext_d = 1'b0;
            end else if (key_code == KC_BREAK) begin
                brk_d = 1'b1;
            end else if (key_code == KC_EXT) begin
                ext_d = 1'b1;
            end else begin
                ext_d  = 1'b0;
                is_key = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (is_key && let_dec[NIB_W]) begin
                    buf_let_d = let_dec[NIB_W-1:0];
                    state_d   = ST_HAVE_LETTER;
                end
            end
            ST_HAVE_LETTER: begin
                if (is_key) begin
                    if (let_dec[NIB_W]) begin
                        buf_let_d = let_dec[NIB_W-1:0];
                    end else if (dig_dec[NIB_W]) begin
                        buf_num_d = dig_dec[NIB_W-1:0];
                        state_d   = ST_HAVE_NUMBER;
                    end else if ((key_code == KC_BKSP) || (key_code == KC_ESC)) begin
                        buf_let_d = NO_SHOT;
                        buf_num_d = NO_SHOT;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_HAVE_NUMBER: begin
                if (is_key) begin
                    if (key_code == KC_ENTER) begin
                        state_d = ST_FIRE;
                    end else if (dig_dec[NIB_W]) begin
                        buf_num_d = dig_dec[NIB_W-1:0];
                    end else if (key_code == KC_BKSP) begin
                        buf_num_d = NO_SHOT;
                        state_d   = ST_HAVE_LETTER;
                    end else if (key_code == KC_ESC) begin
                        buf_let_d = NO_SHOT;
                        buf_num_d = NO_SHOT;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_FIRE: begin
                buf_let_d = NO_SHOT;
                buf_num_d = NO_SHOT;
                turn_d    = ~turn_q;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef SHOT_TIMEOUT_EN
        // Count only idle cycles of a partial entry; any accepted byte restarts.
        if (((state_q == ST_HAVE_LETTER) || (state_q == ST_HAVE_NUMBER)) && !key_take) begin
            if (cnt_q == CNT_LAST) begin
                buf_let_d = NO_SHOT;
                buf_num_d = NO_SHOT;
                state_d   = ST_IDLE;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
`endif

        // Coordinate is presented only while the registered state is FIRE.
        shot_d   = (state_d == ST_FIRE);
        letter_d = shot_d ? buf_let_d : NO_SHOT;
        number_d = shot_d ? buf_num_d : NO_SHOT;
    end

    assign letter      = letter_q;
    assign number      = number_q;
    assign shot_valid  = shot_q;
    assign playerTurn  = turn_q;
    assign cur_letter  = buf_let_q;
    assign cur_number  = buf_num_q;
    assign entry_state = 2'(state_q);

endmodule
